regbank_write_arbiter: RTL and testbench

REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

---
 rtl/regbank_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/regbank_write_arbiter.sv | 87 ++++++++
 tb/tb_regbank_write_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_ctrl_pkg.sv
// Shared constants and helpers for the register-bank write path.
// Requester indices, the default requester count and the index-to-enable decode.
package regbank_ctrl_pkg;

   localparam int unsigned NREQ_DEFAULT = 3;

   localparam int unsigned REQ_ALU  = 0;
   localparam int unsigned REQ_LOAD = 1;
   localparam int unsigned REQ_EXT  = 2;

   localparam int unsigned NREG = 16;

   function automatic logic [15:0] decode_onehot16(input logic [3:0] idx);
      logic [15:0] res;
      res      = 16'h0000;
      res[idx] = 1'b1;
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: the search begins one past the pointer and wraps.
// stall blocks every grant; the caller folds reset into stall.
module rr_arbiter #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic            stall,
   input  logic [IW-1:0]   pointer,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            gnt_valid
);

   logic [IW:0] sum_s;
   logic [IW:0] cand_s;
   logic        hit_s;
   logic        found_s;

   // First requesting index found after the pointer, in wrapped order, wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found_s = 1'b0;
      sum_s   = '0;
      cand_s  = '0;
      hit_s   = 1'b0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         sum_s   = {1'b0, pointer} + (IW+1)'(k);
         cand_s  = (sum_s >= (IW+1)'(NREQ)) ? (sum_s - (IW+1)'(NREQ)) : sum_s;
         hit_s   = req[cand_s[IW-1:0]] & ~stall & ~found_s;
         gnt[cand_s[IW-1:0]] = gnt[cand_s[IW-1:0]] | hit_s;
         gnt_idx = hit_s ? cand_s[IW-1:0] : gnt_idx;
         found_s = found_s | hit_s;
      end
      gnt_valid = found_s;
   end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Arbitrates several write requesters onto the single register-bank write port.
// Writes appear one cycle after the grant; protected destinations are dropped and flagged.
module regbank_write_arbiter
   import regbank_ctrl_pkg::*;
#(
   parameter int unsigned NREQ         = NREQ_DEFAULT,
   parameter int unsigned DW           = 16,
   parameter logic [15:0] PROTECT_MASK = 16'h0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*4-1:0]  dest,
   input  logic [NREQ*DW-1:0] data,
   input  logic               stall,
   output logic [NREQ-1:0]    gnt,
   output logic [DW-1:0]      ALUBus,
   output logic [15:0]        regEnable,
   output logic               wr_drop,
   output logic [15:0]        wr_count
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0] last_grant_r;
   logic [IW-1:0] gnt_idx_s;
   logic          gnt_valid_s;
   logic          arb_block_s;
   logic [3:0]    sel_dest_s;
   logic [DW-1:0] sel_data_s;
   logic          protected_s;
   logic          write_ok_s;

   // Holding reset low must also hide the grant, so no request is consumed while in reset.
   assign arb_block_s = stall | ~reset;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_arbiter (
      .req       (req),
      .stall     (arb_block_s),
      .pointer   (last_grant_r),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx_s),
      .gnt_valid (gnt_valid_s)
   );

   // AND-OR mux of the granted requester's destination and data, then the protect lookup.
   always_comb begin
      sel_dest_s = 4'h0;
      sel_data_s = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         sel_dest_s = sel_dest_s | (dest[4*i +: 4] & {4{gnt[i]}});
         sel_data_s = sel_data_s | (data[DW*i +: DW] & {DW{gnt[i]}});
      end
      protected_s = PROTECT_MASK[sel_dest_s];
      write_ok_s  = gnt_valid_s & ~protected_s;
   end

   // Round-robin pointer: moves only on a grant, restarts so requester 0 leads after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant_r <= IW'(NREQ - 1);
      end else if (gnt_valid_s) begin
         last_grant_r <= gnt_idx_s;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   // Write port, drop flag and saturating completed-write counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         regEnable <= 16'h0000;
         ALUBus    <= '0;
         wr_drop   <= 1'b0;
         wr_count  <= 16'h0000;
      end else begin
         regEnable <= write_ok_s ? decode_onehot16(sel_dest_s) : 16'h0000;
         ALUBus    <= gnt_valid_s ? sel_data_s : ALUBus;
         wr_drop   <= gnt_valid_s & protected_s;
         wr_count  <= (write_ok_s && (wr_count != 16'hFFFF)) ? (wr_count + 16'h0001) : wr_count;
      end
   end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model of the write port.
module tb_regbank_write_arbiter;
   import regbank_ctrl_pkg::*;

   localparam int          NREQ  = 3;
   localparam int          DW    = 16;
   localparam logic [15:0] PMASK = 16'h8001;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*4-1:0]    dest = '0;
   logic [NREQ*DW-1:0]   data = '0;
   logic                 stall = 1'b0;
   logic [NREQ-1:0]      gnt;
   logic [DW-1:0]        ALUBus;
   logic [15:0]          regEnable;
   logic                 wr_drop;
   logic [15:0]          wr_count;

   always #5 clk = ~clk;

   regbank_write_arbiter #(
      .NREQ         (NREQ),
      .DW           (DW),
      .PROTECT_MASK (PMASK)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .dest      (dest),
      .data      (data),
      .stall     (stall),
      .gnt       (gnt),
      .ALUBus    (ALUBus),
      .regEnable (regEnable),
      .wr_drop   (wr_drop),
      .wr_count  (wr_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: what the registered outputs must show now, and the round-robin history.
   int          m_last = NREQ - 1;
   logic [15:0] m_en   = 16'h0000;
   logic [15:0] m_bus  = 16'h0000;
   logic        m_drop = 1'b0;
   logic [15:0] m_cnt  = 16'h0000;
   int          granted_idx = -1;

   bit          pend [NREQ];
   logic [3:0]  pdest [NREQ];
   logic [15:0] pdata [NREQ];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_pick();
      int c;
      if (!reset || stall) return -1;
      for (int k = 1; k <= NREQ; k++) begin
         c = (m_last + k) % NREQ;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   // Compare process: checks every cycle, then advances the model across the coming edge.
   initial begin
      int          g;
      logic [3:0]  d;
      logic [NREQ-1:0] exp_gnt;
      forever begin
         @(negedge clk);
         g = model_pick();
         exp_gnt = '0;
         if (g >= 0) exp_gnt[g] = 1'b1;
         check("gnt", gnt, exp_gnt);
         check("regEnable", regEnable, m_en);
         check("ALUBus", ALUBus, m_bus);
         check("wr_drop", wr_drop, m_drop);
         check("wr_count", wr_count, m_cnt);
         if (!reset) begin
            m_en = 16'h0000; m_bus = 16'h0000; m_drop = 1'b0; m_cnt = 16'h0000; m_last = NREQ - 1;
         end else if (g >= 0) begin
            m_last = g;
            d      = dest[4*g +: 4];
            m_bus  = data[DW*g +: DW];
            if (PMASK[d]) begin
               m_en = 16'h0000; m_drop = 1'b1;
            end else begin
               m_en = 16'h0001 << d; m_drop = 1'b0;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
            end
         end else begin
            m_en = 16'h0000; m_drop = 1'b0;
         end
         granted_idx = g;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic random_cycles(input int n, input bit allow_new);
      for (int cyc = 0; cyc < n; cyc++) begin
         step();
         if (granted_idx >= 0) pend[granted_idx] = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && allow_new && ($urandom_range(0, 1) == 1)) begin
               pend[i]  = 1'b1;
               pdest[i] = 4'($urandom_range(0, 15));
               pdata[i] = 16'($urandom);
            end
            req[i]           = pend[i];
            dest[4*i +: 4]   = pdest[i];
            data[DW*i +: DW] = pdata[i];
         end
         stall = allow_new ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
   endtask

   initial begin
      int guard;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1'b0; pdest[i] = 4'h0; pdata[i] = 16'h0000;
      end
      repeat (3) step();

      // Three requesters after reset: strict 0,1,2 order and one write per cycle.
      reset = 1'b1; req = 3'b111;
      dest = {4'd3, 4'd2, 4'd1}; data = {16'hCCCC, 16'hBBBB, 16'hAAAA};
      #3 check("r32_gnt0", gnt, 3'b001); check("r32_en_idle", regEnable, 16'h0000);
      step(); req = 3'b110;
      #3 check("r32_gnt1", gnt, 3'b010); check("r32_en0", regEnable, 16'h0002);
      check("r32_bus0", ALUBus, 16'hAAAA); check("r32_cnt1", wr_count, 16'h0001);
      step(); req = 3'b100;
      #3 check("r32_gnt2", gnt, 3'b100); check("r32_en1", regEnable, 16'h0004);
      check("r32_bus1", ALUBus, 16'hBBBB);
      step(); req = 3'b000;
      #3 check("r32_gnt_none", gnt, 3'b000); check("r32_en2", regEnable, 16'h0008);
      check("r32_bus2", ALUBus, 16'hCCCC); check("r32_cnt3", wr_count, 16'h0003);
      step();
      #3 check("r32_en_after", regEnable, 16'h0000); check("r32_bus_hold", ALUBus, 16'hCCCC);

      // Stall blocks grants for two cycles; requester 0 wins once released.
      req = 3'b011; stall = 1'b1; dest = {4'd0, 4'd7, 4'd6};
      #3 check("r33_gnt_stall0", gnt, 3'b000); check("r33_en_stall0", regEnable, 16'h0000);
      step();
      #3 check("r33_gnt_stall1", gnt, 3'b000); check("r33_en_stall1", regEnable, 16'h0000);
      step(); stall = 1'b0;
      #3 check("r33_gnt_first", gnt, 3'b001);
      step(); req = 3'b010;
      #3 check("r33_gnt_second", gnt, 3'b010); check("r33_en_first", regEnable, 16'h0040);
      step(); req = 3'b000;
      #3 check("r33_en_second", regEnable, 16'h0080); check("r33_cnt", wr_count, 16'h0005);

      // Requester 1 writes protected register 0: dropped and flagged for exactly one cycle.
      req = 3'b010; dest = {4'd0, 4'd0, 4'd6}; data = {16'h0000, 16'h1234, 16'h0000};
      #3 check("r34_gnt", gnt, 3'b010);
      step(); req = 3'b000;
      #3 check("r34_en", regEnable, 16'h0000); check("r34_drop", wr_drop, 1'b1);
      check("r34_cnt", wr_count, 16'h0005);
      step();
      #3 check("r34_drop_clear", wr_drop, 1'b0); check("r34_cnt_after", wr_count, 16'h0005);

      // Randomized traffic with held requests and random stalls, then drain.
      random_cycles(3000, 1'b1);
      random_cycles(10, 1'b0);
      step(); req = '0; stall = 1'b0;

      // Drive the counter to 16'hFFFE, then confirm it saturates.
      dest = {4'd5, 4'd5, 4'd5}; data = {16'h3333, 16'h2222, 16'h1111};
      guard = 0;
      while (m_cnt != 16'hFFFE && guard < 70000) begin
         req = 3'b111;
         step();
         guard++;
      end
      req = 3'b000;
      #3 check("r35_preload", wr_count, 16'hFFFE);
      step(); req = 3'b111;
      repeat (3) step();
      req = 3'b000;
      #3 check("r35_sat", wr_count, 16'hFFFF); check("r35_last_en", regEnable, 16'h0020);
      step();
      #3 check("r35_sat_hold", wr_count, 16'hFFFF);

      // Grant to requester 2, then reset: grant suppressed, outputs cleared, requester 0 first.
      req = 3'b100; dest = {4'd9, 4'd0, 4'd0}; data = {16'h9999, 16'h0000, 16'h0000};
      #3 check("r36_gnt2", gnt, 3'b100);
      step(); reset = 1'b0; req = 3'b011;
      #3 check("r36_gnt_in_reset", gnt, 3'b000); check("r36_en_pending", regEnable, 16'h0200);
      step(); reset = 1'b1;
      #3 check("r36_en_zero", regEnable, 16'h0000); check("r36_bus_zero", ALUBus, 16'h0000);
      check("r36_drop_zero", wr_drop, 1'b0); check("r36_cnt_zero", wr_count, 16'h0000);
      check("r36_first_gnt", gnt, 3'b001);
      step(); req = 3'b000;

      // Pointer reset: last grant was 0, yet requester 0 must lead again after reset.
      step(); reset = 1'b0;
      step(); reset = 1'b1; req = 3'b011;
      #3 check("r27_ptr_reset", gnt, 3'b001);
      step(); req = 3'b000;
      repeat (2) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
